// File: rtl/tamagotchi_input_scheduler.sv
// Front end for the tamagotchi care FSM: button sync/debounce, request queue,
// round-robin action offer, 1 s decay tick and long-press test/reset pulses.
module tamagotchi_input_scheduler #(
   parameter int TICK_DIV     = 50000000,
   parameter int DEBOUNCE_CYC = 1000000,
   parameter int LONG_S       = 5,
   parameter int RESET_S      = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_salud_raw,
   input  logic       btn_energia_raw,
   input  logic       btn_hambre_raw,
   input  logic       btn_diversion_raw,
   input  logic       btn_mode_raw,
   input  logic       ledsign,
   input  logic       act_ready,
   output logic       act_valid,
   output logic [1:0] act_sel,
   output logic [3:0] pending,
   output logic       tick_1s,
   output logic       test_req,
   output logic       reset_req
);

   localparam int TW = $clog2(TICK_DIV + 1);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int HW = $clog2(RESET_S + 1);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
   localparam logic [DW-1:0] DB_ONE    = DW'(1);
   localparam logic [HW-1:0] HOLD_LONG = HW'(LONG_S);
   localparam logic [HW-1:0] HOLD_RST  = HW'(RESET_S);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_OFFER = 1'b1;

   localparam int BTN_MODE = 4;

   logic [4:0]    rawBtn;
   logic [4:0]    syncA_q;
   logic [4:0]    syncB_q;
   logic [4:0]    dbLevel_q;
   logic [4:0]    dbLevel_d;
   logic [4:0]    dbPrev_q;
   logic [DW-1:0] dbCnt_q [5];
   logic [DW-1:0] dbCnt_d [5];

   logic [4:0]    rise;
   logic [3:0]    capture;
   logic          modeRise;

   logic [TW-1:0] tickCnt_q;
   logic [TW-1:0] tickCnt_d;
   logic          tickNow;

   logic [HW-1:0] holdCnt_q;
   logic [HW-1:0] holdCnt_d;
   logic          holdInc;
   logic          testReq_q;
   logic          testReq_d;
   logic          resetReq_q;
   logic          resetReq_d;

   logic [0:0]    state_q;
   logic [0:0]    state_d;
   logic [1:0]    sel_q;
   logic [1:0]    sel_d;
   logic [1:0]    rr_q;
   logic [1:0]    rr_d;
   logic [3:0]    pending_q;
   logic [3:0]    pending_d;
   logic [3:0]    grantClr;
   logic [1:0]    pick;

   assign rawBtn = {btn_mode_raw, btn_diversion_raw, btn_hambre_raw,
                    btn_energia_raw, btn_salud_raw};

   // Two-flop synchroniser on every raw button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncA_q <= '0;
         syncB_q <= '0;
      end else begin
         syncA_q <= rawBtn;
         syncB_q <= syncA_q;
      end
   end

   always_comb begin
      dbLevel_d = dbLevel_q;
      for (int b = 0; b < 5; b++) begin
         dbCnt_d[b] = '0;
         if (syncB_q[b] != dbLevel_q[b]) begin
            if (dbCnt_q[b] == DB_LAST) begin
               dbLevel_d[b] = ~dbLevel_q[b];
            end else begin
               dbCnt_d[b] = dbCnt_q[b] + DB_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbLevel_q <= '0;
         dbPrev_q  <= '0;
         for (int b = 0; b < 5; b++) begin
            dbCnt_q[b] <= '0;
         end
      end else begin
         dbLevel_q <= dbLevel_d;
         dbPrev_q  <= dbLevel_q;
         for (int b = 0; b < 5; b++) begin
            dbCnt_q[b] <= dbCnt_d[b];
         end
      end
   end

   // Energy requests only count while the pet is awake.
   assign rise     = dbLevel_q & ~dbPrev_q;
   assign capture  = {rise[3], rise[2], rise[1] & ledsign, rise[0]};
   assign modeRise = rise[BTN_MODE];

   assign tickNow   = (tickCnt_q == TICK_LAST);
   assign tickCnt_d = tickNow ? '0 : tickCnt_q + TICK_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tickCnt_q <= '0;
      end else begin
         tickCnt_q <= tickCnt_d;
      end
   end

   always_comb begin
      holdCnt_d = holdCnt_q;
      holdInc   = 1'b0;
      if (modeRise) begin
         holdCnt_d = '0;
      end else if (tickNow && dbLevel_q[BTN_MODE] && (holdCnt_q != HOLD_RST)) begin
         holdCnt_d = holdCnt_q + HOLD_ONE;
         holdInc   = 1'b1;
      end
      testReq_d  = holdInc && (holdCnt_d == HOLD_LONG);
      resetReq_d = holdInc && (holdCnt_d == HOLD_RST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         holdCnt_q  <= '0;
         testReq_q  <= 1'b0;
         resetReq_q <= 1'b0;
      end else begin
         holdCnt_q  <= holdCnt_d;
         testReq_q  <= testReq_d;
         resetReq_q <= resetReq_d;
      end
   end

   // Lowest offset from the round-robin pointer wins, so scan from the far end.
   always_comb begin
      pick = rr_q;
      for (int i = 3; i >= 0; i--) begin
         if (pending_q[rr_q + 2'(i)]) begin
            pick = rr_q + 2'(i);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      rr_d      = rr_q;
      grantClr  = '0;
      pending_d = pending_q;
      if (resetReq_q) begin
         state_d   = S_IDLE;
         rr_d      = '0;
         pending_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pending_q != 4'd0) begin
                  sel_d   = pick;
                  state_d = S_OFFER;
               end
            end
            S_OFFER: begin
               if (act_ready) begin
                  grantClr = 4'b0001 << sel_q;
                  rr_d     = sel_q + 2'd1;
                  state_d  = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
         pending_d = (pending_q & ~grantClr) | capture;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sel_q     <= '0;
         rr_q      <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         rr_q      <= rr_d;
         pending_q <= pending_d;
      end
   end

   assign act_valid = (state_q == S_OFFER);
   assign act_sel   = sel_q;
   assign pending   = pending_q;
   assign tick_1s   = tickNow;
   assign test_req  = testReq_q;
   assign reset_req = resetReq_q;

endmodule
